sc_speed_scheduler: RTL and testbench

SC_SPEED_SCHEDULER -- requirements
Module: sc_speed_scheduler

---
 rtl/sc_speed_scheduler_pkg.sv | 30 +++
 rtl/sc_tick_prescaler.sv | 48 ++++
 rtl/sc_speed_scheduler.sv | 137 +++++++++++++
 tb/tb_sc_speed_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_speed_scheduler_pkg.sv
// Purpose: shared state encodings and period-clamp helper for the speed scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sc_speed_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CRASH = 2'd3
    } sched_state_e;

    // Tick period for a given level: max(base - level*step, min_p).
    // The comparison is arranged so that base - level*step is only formed
    // when it cannot drop below min_p, which also rules out any wrap.
    function automatic longint unsigned period_clamp(
        input longint unsigned level,
        input longint unsigned base,
        input longint unsigned step,
        input longint unsigned min_p
    );
        longint unsigned reduction;
        reduction = level * step;
        if (reduction + min_p >= base) begin
            return min_p;
        end
        return base - reduction;
    endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Purpose: free-running prescaler that wraps and flags a match when count >= period-1.
// Latency: match_o is combinational from the count register; the count clears on the match edge.
// Backpressure: none; enable_i freezes the count, clear_i zeroes it (clear wins).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   enable_i       advance the count this cycle
//   clear_i        force the count to zero this cycle
//   period_i       current period in clocks (must be >= 1)
//   match_o        count has reached period-1 (or beyond, after a period shrink)
module sc_tick_prescaler
    import sc_speed_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] period_i,
    output logic             match_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // ">=" rather than "==" so a level-up that shortens the period below
    // the current count still produces a tick on the next enabled cycle.
    assign match_o = (count_q >= (period_i - WIDTH'(1)));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = match_o ? '0 : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sc_speed_scheduler.sv
// Purpose: game speed scheduler: IDLE/RUN/PAUSE/CRASH control with level-dependent tick rate.
// Latency: all outputs registered; a tick appears the cycle after the prescaler match edge.
// Backpressure: none; all inputs are active-low levels sampled on every rising edge.
//
// Ports:
//   SC_SPEED_SCHEDULER_CLOCK_50       clock
//   SC_SPEED_SCHEDULER_RESET_InHigh   asynchronous active-high reset
//   SC_SPEED_SCHEDULER_start_InLow    start request (IDLE only)
//   SC_SPEED_SCHEDULER_pause_InLow    hold paused while low
//   SC_SPEED_SCHEDULER_crash_InLow    collision
//   SC_SPEED_SCHEDULER_levelup_InLow  level increment, one per low cycle
//   SC_SPEED_SCHEDULER_tick_OutLow    one-cycle active-low count strobe
//   SC_SPEED_SCHEDULER_level_OutBUS   current speed level
//   SC_SPEED_SCHEDULER_state_OutBUS   current state encoding
module sc_speed_scheduler
    import sc_speed_scheduler_pkg::*;
#(
    parameter int unsigned PRESCALER_WIDTH = 24,
    parameter int unsigned LEVEL_WIDTH     = 3,
    parameter int unsigned BASE_PERIOD     = 5000000,
    parameter int unsigned PERIOD_STEP     = 500000,
    parameter int unsigned MIN_PERIOD      = 1000000,
    parameter int unsigned CRASH_HOLD      = 50000000
) (
    input  logic                   SC_SPEED_SCHEDULER_CLOCK_50,
    input  logic                   SC_SPEED_SCHEDULER_RESET_InHigh,
    input  logic                   SC_SPEED_SCHEDULER_start_InLow,
    input  logic                   SC_SPEED_SCHEDULER_pause_InLow,
    input  logic                   SC_SPEED_SCHEDULER_crash_InLow,
    input  logic                   SC_SPEED_SCHEDULER_levelup_InLow,
    output logic                   SC_SPEED_SCHEDULER_tick_OutLow,
    output logic [LEVEL_WIDTH-1:0] SC_SPEED_SCHEDULER_level_OutBUS,
    output logic [1:0]             SC_SPEED_SCHEDULER_state_OutBUS
);

    localparam int unsigned HOLD_W = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
    localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL = '1;

    logic clk;
    logic rst;
    assign clk = SC_SPEED_SCHEDULER_CLOCK_50;
    assign rst = SC_SPEED_SCHEDULER_RESET_InHigh;

    sched_state_e               state_q,  state_d;
    logic [LEVEL_WIDTH-1:0]     level_q,  level_d;
    logic [HOLD_W-1:0]          hold_q,   hold_d;
    logic                       tick_n_q, tick_n_d;

    logic                       psc_en;
    logic                       psc_clr;
    logic                       psc_match;
    logic [PRESCALER_WIDTH-1:0] period;

    assign period = PRESCALER_WIDTH'(period_clamp(64'(level_q), 64'(BASE_PERIOD),
                                                  64'(PERIOD_STEP), 64'(MIN_PERIOD)));

    sc_tick_prescaler #(
        .WIDTH (PRESCALER_WIDTH)
    ) u_prescaler (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (psc_en),
        .clear_i  (psc_clr),
        .period_i (period),
        .match_o  (psc_match)
    );

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        hold_d   = hold_q;
        tick_n_d = 1'b1;
        psc_en   = 1'b0;
        psc_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!SC_SPEED_SCHEDULER_start_InLow) begin
                    state_d = ST_RUN;
                    level_d = '0;
                    psc_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // crash beats pause beats levelup; only an undisturbed RUN
                // cycle advances the prescaler or emits a tick.
                if (!SC_SPEED_SCHEDULER_crash_InLow) begin
                    state_d = ST_CRASH;
                    hold_d  = HOLD_W'(CRASH_HOLD - 1);
                    level_d = '0;
                    psc_clr = 1'b1;
                end else if (!SC_SPEED_SCHEDULER_pause_InLow) begin
                    state_d = ST_PAUSE;
                end else begin
                    psc_en   = 1'b1;
                    tick_n_d = ~psc_match;
                    if (!SC_SPEED_SCHEDULER_levelup_InLow && (level_q != MAX_LEVEL)) begin
                        level_d = level_q + LEVEL_WIDTH'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (SC_SPEED_SCHEDULER_pause_InLow) begin
                    state_d = ST_RUN;
                end
            end
            ST_CRASH: begin
                if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            hold_q   <= '0;
            tick_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            tick_n_q <= tick_n_d;
        end
    end

    assign SC_SPEED_SCHEDULER_tick_OutLow  = tick_n_q;
    assign SC_SPEED_SCHEDULER_level_OutBUS = level_q;
    assign SC_SPEED_SCHEDULER_state_OutBUS = state_q;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Purpose: scoreboard bench for sc_speed_scheduler with small periods.
// Latency: expectations are indexed by posedge count; outputs are sampled on the falling edge.
// Backpressure: n/a.
module tb_sc_speed_scheduler;

    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_n;
    logic          pause_n;
    logic          crash_n;
    logic          levelup_n;
    logic          tick_n;
    logic [LW-1:0] level;
    logic [1:0]    state;

    sc_speed_scheduler #(
        .PRESCALER_WIDTH (8),
        .LEVEL_WIDTH     (LW),
        .BASE_PERIOD     (10),
        .PERIOD_STEP     (2),
        .MIN_PERIOD      (4),
        .CRASH_HOLD      (5)
    ) dut (
        .SC_SPEED_SCHEDULER_CLOCK_50      (clk),
        .SC_SPEED_SCHEDULER_RESET_InHigh  (rst),
        .SC_SPEED_SCHEDULER_start_InLow   (start_n),
        .SC_SPEED_SCHEDULER_pause_InLow   (pause_n),
        .SC_SPEED_SCHEDULER_crash_InLow   (crash_n),
        .SC_SPEED_SCHEDULER_levelup_InLow (levelup_n),
        .SC_SPEED_SCHEDULER_tick_OutLow   (tick_n),
        .SC_SPEED_SCHEDULER_level_OutBUS  (level),
        .SC_SPEED_SCHEDULER_state_OutBUS  (state)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int lvl;
    } tick_exp_t;

    typedef struct {
        int cyc;
        int st;
        int lvl;
        int tk;
    } snap_exp_t;

    tick_exp_t tq[$];
    snap_exp_t sq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_tick(input int c, input int l);
        tick_exp_t e;
        e.cyc = c;
        e.lvl = l;
        tq.push_back(e);
    endtask

    task automatic push_snap(input int c, input int s, input int l, input int t);
        snap_exp_t e;
        e.cyc = c;
        e.st  = s;
        e.lvl = l;
        e.tk  = t;
        sq.push_back(e);
    endtask

    // Returns just after rising edge number c, ready to drive inputs.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every falling edge, retire overdue ticks, match strobes
    // against the tick queue and compare any status snapshot due now.
    always @(negedge clk) begin
        while (tq.size() > 0 && tq[0].cyc < cyc) begin
            n_chk++;
            $display("FAIL missed_tick: expected tick at cycle %0d, still outstanding at cycle %0d",
                     tq[0].cyc, cyc);
            void'(tq.pop_front());
        end
        if (tick_n === 1'b0) begin
            if (tq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
            end else begin
                tick_exp_t e;
                e = tq.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk($sformatf("tick_level@%0d", e.cyc), int'(level), e.lvl);
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            snap_exp_t s;
            s = sq.pop_front();
            chk($sformatf("state@%0d", s.cyc), int'(state), s.st);
            chk($sformatf("level@%0d", s.cyc), int'(level), s.lvl);
            chk($sformatf("tick_n@%0d", s.cyc), int'(tick_n), s.tk);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start_n   = 1'b1;
        pause_n   = 1'b1;
        crash_n   = 1'b1;
        levelup_n = 1'b1;
        push_snap(2, 0, 0, 1);
        wait_cyc(3);
        rst = 1'b0;
        push_snap(5, 0, 0, 1);

        // Start sampled at edge 6: period 10 -> ticks at 16, 26, 36, 46.
        wait_cyc(5);
        start_n = 1'b0;
        for (int i = 1; i <= 4; i++) push_tick(6 + 10 * i, 0);
        push_snap(46, 1, 0, 0);
        wait_cyc(6);
        start_n = 1'b1;

        // Levelup held for edges 47..49 -> level 3, period 4.
        wait_cyc(46);
        levelup_n = 1'b0;
        push_tick(50, 3);
        push_tick(54, 3);
        push_tick(58, 3);
        wait_cyc(49);
        levelup_n = 1'b1;

        // Five more (edges 59..63): saturate at 7, period clamps at 4.
        wait_cyc(58);
        levelup_n = 1'b0;
        push_tick(62, 7);
        push_tick(66, 7);
        push_snap(63, 1, 7, 1);
        wait_cyc(63);
        levelup_n = 1'b1;

        // Crash on tick-due edge 70: CRASH 70..74, RUN at 75, ticks 85, 95.
        wait_cyc(69);
        crash_n = 1'b0;
        push_snap(70, 3, 0, 1);
        push_snap(74, 3, 0, 1);
        push_snap(75, 1, 0, 1);
        push_tick(85, 0);
        push_tick(95, 0);
        wait_cyc(70);
        crash_n = 1'b1;

        // Pause at prescaler 6 for edges 102..108; resume -> tick at 113.
        wait_cyc(101);
        pause_n = 1'b0;
        push_snap(102, 2, 0, 1);
        push_snap(108, 2, 0, 1);
        push_snap(109, 1, 0, 1);
        push_tick(113, 0);
        wait_cyc(108);
        pause_n = 1'b1;

        // Enter CRASH at edge 115, then reset mid-CRASH.
        wait_cyc(114);
        crash_n = 1'b0;
        push_snap(115, 3, 0, 1);
        wait_cyc(115);
        crash_n = 1'b1;
        wait_cyc(116);
        rst = 1'b1;
        push_snap(116, 0, 0, 1);
        wait_cyc(118);
        rst = 1'b0;
        push_snap(125, 0, 0, 1);

        // Restart at edge 131 -> first tick at 141.
        wait_cyc(130);
        start_n = 1'b0;
        push_snap(140, 1, 0, 1);
        push_tick(141, 0);
        wait_cyc(131);
        start_n = 1'b1;

        wait_cyc(150);
        @(negedge clk);
        #1;
        chk("ticks_outstanding", tq.size(), 0);
        chk("snaps_outstanding", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
